// File: rtl/fetch_sequencer.sv
// fetch_sequencer: front-end fetch controller for the combinational decode stage.
// Reads opcode, optional CB-prefix byte and immediate bytes one at a time over a
// single-outstanding byte bus. It drives the decoder's is_instr16 input while the
// byte after 0xCB is fetched, and issues one instruction bundle per valid/ready
// handshake. Execute redirects the front end with flush/flush_pc.
//
// Ports:
//   clk, rst_n                    clock (rising edge); asynchronous active-low reset
//   mem_req/mem_addr              registered byte read request; mem_addr is the PC
//   mem_ack/mem_rdata             read completion and its data byte
//   dec_instr/dec_is_instr16      byte and prefix mode presented to decode
//   dec_ctl_op/dec_is_instr16_o   decode results (control op, 0xCB detected)
//   out_valid/out_ready           instruction bundle handshake
//   out_opcode/out_is_cb          opcode byte, CB-prefixed flag
//   out_imm/out_pc                {hi,lo} immediate, address of first byte
//   flush/flush_pc                redirect, highest priority
//   perf_instr/perf_stall         issue and bus-stall counters (SEQ_PERF_EN only)
//
// Build option: define SEQ_PERF_EN to add the perf_instr/perf_stall counters.

package fetch_seq_pkg;
  typedef enum logic [5:0] {
    CTL_NOP,
    CTL_HALT,
    CTL_STOP,
    CTL_LD_R8_D8,
    CTL_JR,
    CTL_JR_COND,
    CTL_ALU_A_D8,
    CTL_LDPTR_A8_A,
    CTL_LDPTR_A_A8,
    CTL_ADD_SP_D8,
    CTL_LD_HL_SP_D8,
    CTL_LD_R16_D16,
    CTL_LDPTR_D16_SP,
    CTL_JP_A16,
    CTL_JP_COND,
    CTL_CALL_A16,
    CTL_CALL_COND_A16,
    CTL_LDPTR_A16_A,
    CTL_LDPTR_A_A16,
    CTL_OTHER
  } ctl_op_t;
endpackage

module fetch_sequencer
  import fetch_seq_pkg::*;
#(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter int          PERF_W   = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              mem_req,
  output logic [15:0]       mem_addr,
  input  logic              mem_ack,
  input  logic [7:0]        mem_rdata,
  output logic [7:0]        dec_instr,
  output logic              dec_is_instr16,
  input  ctl_op_t           dec_ctl_op,
  input  logic              dec_is_instr16_o,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [7:0]        out_opcode,
  output logic              out_is_cb,
  output logic [15:0]       out_imm,
  output logic [15:0]       out_pc,
`ifdef SEQ_PERF_EN
  output logic [PERF_W-1:0] perf_instr,
  output logic [PERF_W-1:0] perf_stall,
`endif
  input  logic              flush,
  input  logic [15:0]       flush_pc
);

  typedef enum logic [2:0] {
    S_OP,
    S_CB,
    S_IMM_LO,
    S_IMM_HI,
    S_ISSUE,
    S_HALT
  } state_t;

  state_t      state;
  logic [15:0] pc;
  logic        imm_two;     // current instruction carries a 16-bit immediate
  logic        halt_after;  // enter S_HALT once the bundle is accepted
  logic        ack_ok;
  logic        issue_hs;
  logic [1:0]  imm_n;

  function automatic logic [1:0] imm_count(input ctl_op_t op);
    case (op)
      CTL_LD_R8_D8, CTL_JR, CTL_JR_COND, CTL_ALU_A_D8, CTL_LDPTR_A8_A,
      CTL_LDPTR_A_A8, CTL_ADD_SP_D8, CTL_LD_HL_SP_D8:
        imm_count = 2'd1;
      CTL_LD_R16_D16, CTL_LDPTR_D16_SP, CTL_JP_A16, CTL_JP_COND, CTL_CALL_A16,
      CTL_CALL_COND_A16, CTL_LDPTR_A16_A, CTL_LDPTR_A_A16:
        imm_count = 2'd2;
      default:
        imm_count = 2'd0;
    endcase
  endfunction

  function automatic logic is_halt_op(input ctl_op_t op);
    is_halt_op = (op == CTL_HALT) || (op == CTL_STOP);
  endfunction

  assign mem_addr       = pc;
  assign dec_instr      = mem_rdata;
  assign dec_is_instr16 = (state == S_CB);
  assign ack_ok         = mem_req && mem_ack;
  assign issue_hs       = out_valid && out_ready;
  assign imm_n          = imm_count(dec_ctl_op);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_OP;
      pc         <= RESET_PC;
      mem_req    <= 1'b0;
      out_valid  <= 1'b0;
      out_opcode <= 8'h00;
      out_is_cb  <= 1'b0;
      out_imm    <= 16'h0000;
      out_pc     <= 16'h0000;
      imm_two    <= 1'b0;
      halt_after <= 1'b0;
    end else if (flush) begin
      // Redirect: any ack this cycle is dropped and the bus idles one cycle.
      state      <= S_OP;
      pc         <= flush_pc;
      mem_req    <= 1'b0;
      out_valid  <= 1'b0;
      out_is_cb  <= 1'b0;
      out_imm    <= 16'h0000;
      imm_two    <= 1'b0;
      halt_after <= 1'b0;
    end else begin
      case (state)
        S_OP: begin
          if (!mem_req) begin
            mem_req <= 1'b1;
          end else if (ack_ok) begin
            pc         <= pc + 16'd1;
            out_opcode <= mem_rdata;
            out_pc     <= pc;
            out_is_cb  <= 1'b0;
            out_imm    <= 16'h0000;
            imm_two    <= (imm_n == 2'd2);
            if (dec_is_instr16_o) begin
              halt_after <= 1'b0;
              state      <= S_CB;
            end else begin
              halt_after <= is_halt_op(dec_ctl_op);
              if (imm_n == 2'd0) begin
                mem_req   <= 1'b0;
                out_valid <= 1'b1;
                state     <= S_ISSUE;
              end else begin
                state <= S_IMM_LO;
              end
            end
          end
        end
        S_CB: begin
          if (ack_ok) begin
            pc         <= pc + 16'd1;
            out_opcode <= mem_rdata;
            out_is_cb  <= 1'b1;
            mem_req    <= 1'b0;
            out_valid  <= 1'b1;
            state      <= S_ISSUE;
          end
        end
        S_IMM_LO: begin
          if (ack_ok) begin
            pc           <= pc + 16'd1;
            out_imm[7:0] <= mem_rdata;
            if (imm_two) begin
              state <= S_IMM_HI;
            end else begin
              mem_req   <= 1'b0;
              out_valid <= 1'b1;
              state     <= S_ISSUE;
            end
          end
        end
        S_IMM_HI: begin
          if (ack_ok) begin
            pc            <= pc + 16'd1;
            out_imm[15:8] <= mem_rdata;
            mem_req       <= 1'b0;
            out_valid     <= 1'b1;
            state         <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (issue_hs) begin
            out_valid <= 1'b0;
            if (halt_after) begin
              state <= S_HALT;
            end else begin
              mem_req <= 1'b1;
              state   <= S_OP;
            end
          end
        end
        S_HALT: begin
          mem_req <= 1'b0;
        end
        default: begin
          mem_req <= 1'b0;
          state   <= S_OP;
        end
      endcase
    end
  end

`ifdef SEQ_PERF_EN
  // Counters run through flush; only reset clears them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_instr <= '0;
      perf_stall <= '0;
    end else begin
      if (issue_hs) perf_instr <= perf_instr + 1'b1;
      if (mem_req && !mem_ack) perf_stall <= perf_stall + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
module tb_fetch_sequencer;
  import fetch_seq_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_ack = 1'b0;
  logic [7:0]  mem_rdata = 8'h00;
  logic [7:0]  dec_instr;
  logic        dec_is_instr16;
  ctl_op_t     dec_ctl_op;
  logic        dec_is_instr16_o;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [7:0]  out_opcode;
  logic        out_is_cb;
  logic [15:0] out_imm;
  logic [15:0] out_pc;
  logic        flush = 1'b0;
  logic [15:0] flush_pc = 16'h0000;
`ifdef SEQ_PERF_EN
  logic [31:0] perf_instr;
  logic [31:0] perf_stall;
`endif

  fetch_sequencer #(.RESET_PC(16'h0000), .PERF_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .dec_instr(dec_instr), .dec_is_instr16(dec_is_instr16),
    .dec_ctl_op(dec_ctl_op), .dec_is_instr16_o(dec_is_instr16_o),
    .out_valid(out_valid), .out_ready(out_ready), .out_opcode(out_opcode),
    .out_is_cb(out_is_cb), .out_imm(out_imm), .out_pc(out_pc),
`ifdef SEQ_PERF_EN
    .perf_instr(perf_instr), .perf_stall(perf_stall),
`endif
    .flush(flush), .flush_pc(flush_pc)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  logic [40:0] sb[$];          // {opcode, is_cb, imm, pc}
  logic [7:0]  mem [0:65535];
  int          wait_cycles = 0;
  int          wcnt = 0;
  int          reads = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Minimal decoder model for the opcodes used here.
  always_comb begin
    dec_ctl_op       = CTL_NOP;
    dec_is_instr16_o = 1'b0;
    if (dec_is_instr16) begin
      dec_ctl_op = CTL_OTHER;
    end else begin
      case (dec_instr)
        8'h01: dec_ctl_op = CTL_LD_R16_D16;
        8'h3E: dec_ctl_op = CTL_LD_R8_D8;
        8'hC3: dec_ctl_op = CTL_JP_A16;
        8'h76: dec_ctl_op = CTL_HALT;
        8'h10: dec_ctl_op = CTL_STOP;
        8'hCB: dec_is_instr16_o = 1'b1;
        default: dec_ctl_op = CTL_NOP;
      endcase
    end
  end

  // Memory responder with a programmable number of wait cycles per read.
  always @(posedge clk) begin
    #1;
    if (rst_n && mem_req) begin
      if (wcnt >= wait_cycles) begin
        mem_ack   = 1'b1;
        mem_rdata = mem[mem_addr];
        wcnt      = 0;
        reads++;
      end else begin
        mem_ack = 1'b0;
        wcnt++;
      end
    end else begin
      mem_ack = 1'b0;
      wcnt    = 0;
    end
  end

  // Monitor: pops the scoreboard on each handshake and checks hold rules.
  logic        p_valid = 1'b0, p_ready = 1'b0, p_req = 1'b0, p_ack = 1'b0, p_flush = 1'b0;
  logic [40:0] p_bundle = '0;
  logic [15:0] p_addr = '0;
  always @(negedge clk) begin
    logic [40:0] cur;
    logic [40:0] exp_b;
    cur = {out_opcode, out_is_cb, out_imm, out_pc};
    if (!rst_n) begin
      p_valid = 1'b0;
      p_req   = 1'b0;
    end else begin
      if (p_valid && !p_ready && !p_flush)
        check("bundle_hold", {out_valid, cur}, {1'b1, p_bundle});
      if (p_req && !p_ack && !p_flush)
        check("addr_hold", {mem_req, mem_addr}, {1'b1, p_addr});
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_bundle: got %0h expected none", cur);
        end else begin
          exp_b = sb.pop_front();
          check("bundle", cur, exp_b);
        end
      end
      p_valid  = out_valid;
      p_ready  = out_ready;
      p_bundle = cur;
      p_req    = mem_req;
      p_ack    = mem_ack;
      p_addr   = mem_addr;
      p_flush  = flush;
    end
  end

  function automatic logic [40:0] bnd(input logic [7:0] op, input logic cb,
                                      input logic [15:0] imm, input logic [15:0] pc);
    bnd = {op, cb, imm, pc};
  endfunction

  task automatic do_flush(input logic [15:0] pc);
    @(negedge clk);
    flush = 1'b1;
    flush_pc = pc;
    @(negedge clk);
    flush = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    @(negedge clk);
    while (!(sb.size() == 0 && !out_valid && !mem_req) && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) begin
      total++;
      bad++;
      $display("FAIL %s_timeout: got pending=%0d expected 0", name, sb.size());
    end
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    while (!out_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    check({name, "_valid"}, out_valid, 1'b1);
  endtask

  task automatic wait_ack_at(input logic [15:0] a, input string name);
    int n = 0;
    @(negedge clk);
    while (!(mem_ack && mem_addr == a) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check({name, "_ack_seen"}, mem_ack && mem_addr == a, 1'b1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reads = 0;
    rst_n = 1'b1;
  endtask

  initial begin
    int hcnt;
    for (int i = 0; i < 65536; i++) mem[i] = 8'h76;

    // Zero-wait NOP then HALT at reset PC.
    mem[16'h0000] = 8'h00;
    mem[16'h0001] = 8'h76;
    @(negedge clk);
    @(negedge clk);
    check("reset_state",
          {mem_req, mem_addr, out_valid, out_opcode, out_is_cb, out_imm, out_pc, dec_is_instr16},
          {1'b0, 16'h0000, 1'b0, 8'h00, 1'b0, 16'h0000, 16'h0000, 1'b0});
    sb.push_back(bnd(8'h00, 1'b0, 16'h0000, 16'h0000));
    sb.push_back(bnd(8'h76, 1'b0, 16'h0000, 16'h0001));
    rst_n = 1'b1;
    @(negedge clk);
    check("first_req", {mem_req, mem_addr}, {1'b1, 16'h0000});
    @(negedge clk);
    check("nop_latency", {out_valid, out_opcode, mem_addr}, {1'b1, 8'h00, 16'h0001});
    wait_idle("nop");
    check("nop_reads", reads, 2);

    // LD BC,d16 at 0000.
    mem[16'h0000] = 8'h01;
    mem[16'h0001] = 8'h34;
    mem[16'h0002] = 8'h12;
    mem[16'h0003] = 8'h76;
    do_reset();
    sb.push_back(bnd(8'h01, 1'b0, 16'h1234, 16'h0000));
    sb.push_back(bnd(8'h76, 1'b0, 16'h0000, 16'h0003));
    wait_valid("ld16");
    check("ld16_addr", {mem_req, mem_addr}, {1'b0, 16'h0003});
    wait_idle("ld16");
    check("ld16_reads", reads, 4);

    // CB 7C at 0100.
    mem[16'h0100] = 8'hCB;
    mem[16'h0101] = 8'h7C;
    mem[16'h0102] = 8'h76;
    reads = 0;
    sb.push_back(bnd(8'h7C, 1'b1, 16'h0000, 16'h0100));
    sb.push_back(bnd(8'h76, 1'b0, 16'h0000, 16'h0102));
    do_flush(16'h0100);
    wait_ack_at(16'h0101, "cb");
    check("cb_is_instr16", dec_is_instr16, 1'b1);
    wait_idle("cb");
    check("cb_reads", reads, 3);

    // Wait states and back-pressure on LD A,d8 at 0200.
    mem[16'h0200] = 8'h3E;
    mem[16'h0201] = 8'h5A;
    mem[16'h0202] = 8'h76;
    reads = 0;
    wait_cycles = 3;
    out_ready = 1'b0;
    sb.push_back(bnd(8'h3E, 1'b0, 16'h005A, 16'h0200));
    sb.push_back(bnd(8'h76, 1'b0, 16'h0000, 16'h0202));
    do_flush(16'h0200);
    wait_valid("stall");
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_no_read", {mem_req, reads[7:0]}, {1'b0, 8'd2});
    end
    out_ready = 1'b1;
    wait_idle("stall");
    check("stall_reads", reads, 3);
    wait_cycles = 0;

    // JP a16 at FFFF: PC wraps into the immediate bytes.
    mem[16'hFFFF] = 8'hC3;
    mem[16'h0000] = 8'hAD;
    mem[16'h0001] = 8'hDE;
    mem[16'h0002] = 8'h76;
    reads = 0;
    sb.push_back(bnd(8'hC3, 1'b0, 16'hDEAD, 16'hFFFF));
    sb.push_back(bnd(8'h76, 1'b0, 16'h0000, 16'h0002));
    do_flush(16'hFFFF);
    wait_idle("wrap");
    check("wrap_reads", reads, 4);

    // Flush on the same cycle as the high immediate ack.
    mem[16'h0300] = 8'hC3;
    mem[16'h0301] = 8'h11;
    mem[16'h0302] = 8'h22;
    mem[16'h0038] = 8'h76;
    do_flush(16'h0300);
    wait_ack_at(16'h0302, "fl");
    flush = 1'b1;
    flush_pc = 16'h0038;
    sb.push_back(bnd(8'h76, 1'b0, 16'h0000, 16'h0038));
    @(negedge clk);
    flush = 1'b0;
    check("flush_idle", {mem_req, out_valid, mem_addr}, {1'b0, 1'b0, 16'h0038});
    @(negedge clk);
    check("flush_refetch", {mem_req, mem_addr}, {1'b1, 16'h0038});
    wait_idle("fl");

    // HALT holds the bus idle until a flush.
    hcnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (mem_req) hcnt++;
    end
    check("halt_no_req", hcnt, 0);
    mem[16'h0040] = 8'h00;
    mem[16'h0041] = 8'h76;
    sb.push_back(bnd(8'h00, 1'b0, 16'h0000, 16'h0040));
    sb.push_back(bnd(8'h76, 1'b0, 16'h0000, 16'h0041));
    do_flush(16'h0040);
    @(negedge clk);
    check("halt_restart", {mem_req, mem_addr}, {1'b1, 16'h0040});
    wait_idle("restart");

    check("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
